// File: rtl/fei4_record_fifo_pkg.sv
// Shared record formats and constants for the FE-I4 record FIFO.
// DR/DH bit layouts plus a saturating counter helper.
package fei4_record_pkg;

  localparam logic [7:0]  DH_ID       = 8'hE9;
  localparam logic [3:0]  NOTOT       = 4'd15;
  localparam int unsigned COL_MAX_DEF = 80;
  localparam int unsigned ROW_MAX_DEF = 336;
  localparam int unsigned REC_W       = 24;

  typedef struct packed {
    logic [6:0] col;
    logic [8:0] row;
    logic [3:0] tot_t;
    logic [3:0] tot_b;
  } dr_t;

  typedef struct packed {
    logic [7:0] id;
    logic       flag;
    logic [4:0] lv1id;
    logic [9:0] bcid;
  } dh_t;

  // Adds up to three events to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, n};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/fei4_record_fifo_if.sv
// Formatter/serializer-facing bundle of the record FIFO.
// master = formatter + serializer side, slave = the FIFO block.
interface fei4_record_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             HeaderWrite;
  logic             HeaderFlag;
  logic [4:0]       HeaderLv1Id;
  logic [9:0]       HeaderBcId;
  logic             HitWrite;
  logic [6:0]       HitColumn;
  logic [8:0]       HitRow;
  logic [3:0]       HitTotTop;
  logic [3:0]       HitTotBottom;
  logic             HitReady;
  logic             RecordValid;
  logic [23:0]      RecordData;
  logic             RecordRead;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic [7:0]       DropCount;
  logic [7:0]       HitsInEvent;

  modport master (
    output HeaderWrite, HeaderFlag, HeaderLv1Id, HeaderBcId,
    output HitWrite, HitColumn, HitRow, HitTotTop, HitTotBottom,
    output RecordRead,
    input  HitReady, RecordValid, RecordData, Count, Overflow, DropCount, HitsInEvent
  );

  modport slave (
    input  HeaderWrite, HeaderFlag, HeaderLv1Id, HeaderBcId,
    input  HitWrite, HitColumn, HitRow, HitTotTop, HitTotBottom,
    input  RecordRead,
    output HitReady, RecordValid, RecordData, Count, Overflow, DropCount, HitsInEvent
  );

endinterface

// File: rtl/fei4_record_fifo_sync_fifo_sa.sv
// Single-clock show-ahead FIFO: the head word sits in a register, so a word
// pushed into an empty FIFO is presented on the following cycle.
module sync_fifo_sa #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pop_en_c, push_en_c;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    pop_en_c  = pop_i && (count_q != '0);
    push_en_c = push_i && ((count_q < CW'(DEPTH)) || pop_en_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(push_en_c) - CW'(pop_en_c);
    rdata_d   = rdata_q;
    if (push_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Next head is either a word already stored or the one arriving now.
    if ((count_q - CW'(pop_en_c)) == '0) begin
      if (push_en_c) rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_en_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fei4_record_fifo.sv
// FE-I4 record encoder and filter in front of a show-ahead FIFO.
// Turns hits/headers into DR/DH words, applies back-pressure and keeps drop stats.
module fei4_record_fifo
  import fei4_record_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned COL_MAX = COL_MAX_DEF,
  parameter int unsigned ROW_MAX = ROW_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fei4_record_fifo_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  logic [REC_W-1:0] fifo_rdata;

  logic             hit_ready_c, pop_c, hdr_ok_c;
  logic             hit_acc_c, notot_c, bad_c, hit_push_c;
  logic             push_c;
  logic [1:0]       drops_c;
  dr_t              dr_c;
  dh_t              dh_c;
  logic [REC_W-1:0] wdata_c;

  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       hits_q, hits_d;

  // Encode, filter and account for every record request of this cycle.
  always_comb begin
    dr_c       = '{col: bus.HitColumn, row: bus.HitRow,
                   tot_t: bus.HitTotTop, tot_b: bus.HitTotBottom};
    dh_c       = '{id: DH_ID, flag: bus.HeaderFlag,
                   lv1id: bus.HeaderLv1Id, bcid: bus.HeaderBcId};
    hit_ready_c = (fifo_count < CNT_W'(DEPTH)) && !bus.HeaderWrite;
    pop_c       = bus.RecordRead && fifo_valid;
    hdr_ok_c    = (fifo_count < CNT_W'(DEPTH)) || pop_c;
    hit_acc_c   = bus.HitWrite && hit_ready_c;
    notot_c     = (bus.HitTotTop == NOTOT) && (bus.HitTotBottom == NOTOT);
    bad_c       = (bus.HitColumn == 7'd0) || (bus.HitColumn > 7'(COL_MAX)) ||
                  (bus.HitRow == 9'd0)    || (bus.HitRow > 9'(ROW_MAX));
    hit_push_c  = hit_acc_c && !notot_c && !bad_c;
    push_c      = bus.HeaderWrite ? hdr_ok_c : hit_push_c;
    wdata_c     = bus.HeaderWrite ? REC_W'(dh_c) : REC_W'(dr_c);
    drops_c     = 2'(bus.HeaderWrite && !hdr_ok_c) +
                  2'(bus.HitWrite && !hit_ready_c) +
                  2'(hit_acc_c && !notot_c && bad_c);
    ovf_d       = ovf_q || (drops_c != 2'd0);
    drop_d      = sat_add8(drop_q, drops_c);
    hits_d      = hits_q;
    if (bus.HeaderWrite)  hits_d = 8'd0;
    else if (hit_push_c)  hits_d = sat_add8(hits_q, 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
      hits_q <= 8'd0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      hits_q <= hits_d;
    end
  end

  sync_fifo_sa #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .wdata_i (wdata_c),
    .pop_i   (bus.RecordRead),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign bus.HitReady    = hit_ready_c;
  assign bus.RecordValid = fifo_valid;
  assign bus.RecordData  = fifo_rdata;
  assign bus.Count       = fifo_count;
  assign bus.Overflow    = ovf_q;
  assign bus.DropCount   = drop_q;
  assign bus.HitsInEvent = hits_q;

endmodule

// File: tb/tb_fei4_record_fifo.sv
// Randomized scoreboard bench for fei4_record_fifo against a queue-based model.
module tb_fei4_record_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fei4_record_fifo_if #(.DEPTH(DEPTH)) bus ();

  fei4_record_fifo #(.DEPTH(DEPTH), .COL_MAX(80), .ROW_MAX(336)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain occupancy count, statistics and expected-word queue.
  int m_cnt, m_drop, m_hits;
  bit m_ovf;
  int sb[$];
  int hold_word;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output monitor: head word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.RecordValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("record_data", int'(bus.RecordData), sb[0]);
          hold_word = sb[0];
          if (bus.RecordRead) void'(sb.pop_front());
        end
      end else begin
        chk("record_hold", int'(bus.RecordData), hold_word);
      end
    end
  end

  task automatic idle_inputs();
    bus.HeaderWrite  = 1'b0; bus.HeaderFlag = 1'b0;
    bus.HeaderLv1Id  = '0;   bus.HeaderBcId = '0;
    bus.HitWrite     = 1'b0; bus.HitColumn  = '0; bus.HitRow = '0;
    bus.HitTotTop    = '0;   bus.HitTotBottom = '0;
    bus.RecordRead   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("hitready_in_reset", int'(bus.HitReady), int'(m_cnt < DEPTH));
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = 0; m_drop = 0; m_hits = 0; m_ovf = 0;
    sb.delete();
    hold_word = 0;
  endtask

  // One cycle: check registered state, drive inputs, predict, advance the clock.
  task automatic step(input bit hw, input bit fl, input int lv1, input int bc,
                      input bit hitw, input int col, input int row,
                      input int tt, input int tb, input bit rr);
    bit full, pop, ready;
    int drops;
    chk("count", int'(bus.Count), m_cnt);
    chk("record_valid", int'(bus.RecordValid), int'(m_cnt != 0));
    chk("overflow", int'(bus.Overflow), int'(m_ovf));
    chk("drop_count", int'(bus.DropCount), m_drop);
    chk("hits_in_event", int'(bus.HitsInEvent), m_hits);
    bus.HeaderWrite  = hw;  bus.HeaderFlag = fl;
    bus.HeaderLv1Id  = 5'(lv1); bus.HeaderBcId = 10'(bc);
    bus.HitWrite     = hitw; bus.HitColumn = 7'(col); bus.HitRow = 9'(row);
    bus.HitTotTop    = 4'(tt); bus.HitTotBottom = 4'(tb);
    bus.RecordRead   = rr;
    #1;
    full  = (m_cnt >= DEPTH);
    pop   = rr && (m_cnt > 0);
    ready = !full && !hw;
    chk("hit_ready", int'(bus.HitReady), int'(ready));
    drops = 0;
    if (hw) begin
      if (!full || pop) begin
        sb.push_back('hE9 * 65536 + fl * 32768 + lv1 * 1024 + bc);
        m_cnt++;
      end else begin
        drops++;
      end
      m_hits = 0;
    end
    if (hitw) begin
      if (!ready) drops++;
      else if (tt == 15 && tb == 15) ;
      else if (col < 1 || col > 80 || row < 1 || row > 336) drops++;
      else begin
        sb.push_back(col * 131072 + row * 256 + tt * 16 + tb);
        m_cnt++;
        if (m_hits < 255) m_hits++;
      end
    end
    if (pop) m_cnt--;
    if (drops > 0) m_ovf = 1;
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    @(posedge clk); #1;
  endtask

  task automatic hit(input int col, input int row, input int tt, input int tb, input bit rr);
    step(0, 0, 0, 0, 1, col, row, tt, tb, rr);
  endtask

  task automatic hdr(input bit fl, input int lv1, input int bc, input bit rr);
    step(1, fl, lv1, bc, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  initial begin
    m_cnt = 0; m_drop = 0; m_hits = 0; m_ovf = 0; hold_word = 0;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    chk("data_after_reset", int'(bus.RecordData), 0);

    // Header, then a hit that pops it, then a no-ToT hit and two illegal hits.
    hdr(0, 3, 'h155, 0);
    chk("first_dh", int'(bus.RecordData), 'hE90D55);
    hit(5, 10, 3, 14, 1);
    chk("first_dr", int'(bus.RecordData), 'h0A0A3E);
    hit(7, 20, 15, 15, 0);
    hit(81, 10, 1, 1, 0);
    hit(5, 0, 1, 1, 0);
    hit(80, 336, 2, 2, 0);
    hit(1, 1, 15, 0, 0);
    for (int i = 0; i < 6; i++) idle(1);

    // Fill to full, header with pop while full, header without pop is dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) hit(i + 1, i + 2, i % 16, 3, 0);
    hit(9, 9, 1, 1, 0);
    hdr(1, 7, 'h3FF, 1);
    hdr(0, 8, 'h001, 0);
    for (int i = 0; i < DEPTH + 3; i++) idle(1);

    // Header and hit together: only the header goes in, hit follows next cycle.
    step(1, 0, 2, 'h0AA, 1, 12, 34, 5, 6, 0);
    hit(12, 34, 5, 6, 0);
    idle(1); idle(1); idle(1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 7; i++) hit(3, 4 + i, 1, 2, 0);
    do_reset();
    idle(0);

    // Counter saturation: illegal hits and a long stream of valid hits.
    for (int i = 0; i < 300; i++) hit(0, 5, 1, 1, ($urandom % 2) == 1);
    hdr(0, 1, 1, 1);
    for (int i = 0; i < 300; i++) hit(40, 100, 4, 4, 1);
    for (int i = 0; i < DEPTH + 2; i++) idle(1);

    // Randomized traffic with occasional protocol violations.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      bit hw, hitw, rr;
      int tt, tb;
      hw   = ($urandom % 8) == 0;
      hitw = ($urandom % 3) != 0;
      if (hitw && !((m_cnt < DEPTH) && !hw) && ($urandom % 10) != 0) hitw = 0;
      tt = $urandom_range(0, 15);
      tb = $urandom_range(0, 15);
      if (($urandom % 10) == 0) begin tt = 15; tb = 15; end
      rr = ($urandom % 2) == 1;
      step(hw, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 1023),
           hitw, $urandom_range(0, 84), $urandom_range(0, 340), tt, tb, rr);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
    idle(0);
    chk("drained_queue", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
